// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: runs the req/gnt/rvalid data-memory transaction,
// aligns and extends load data, and stalls EX while the bus is busy.
module mem_access_unit (
    input  logic        clock,
    input  logic        resetn,
    input  logic        valid_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] address_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  read_rd_in,
    input  logic        write_back_in,
    output logic        stall_out,
    output logic        valid_out,
    output logic        write_back_out,
    output logic [4:0]  read_rd_out,
    output logic [31:0] data_address_out,
    output logic [31:0] data_mem_out,
    output logic        err_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);
    localparam int unsigned STATE_W = 2;
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] REQ  = 2'b01;
    localparam logic [1:0] WAIT = 2'b10;

    logic [STATE_W-1:0] state, state_d;
    logic               cap_load, cap_load_d;
    logic [2:0]         cap_f3, cap_f3_d;
    logic [31:0]        cap_addr, cap_addr_d;
    logic [4:0]         cap_rd, cap_rd_d;
    logic               cap_wb, cap_wb_d;
    logic               store_done, store_done_d;

    logic               valid_d, wb_d, err_d;
    logic [4:0]         rd_d;
    logic [31:0]        addr_d, data_d;
    logic               req_d, we_d;
    logic [31:0]        daddr_d, wdata_d;
    logic [3:0]         be_d;

    logic               is_mem, is_load, f3_ok, misalign, start;
    logic [3:0]         st_be;
    logic [31:0]        st_wdata;
    logic [7:0]         lane_byte;
    logic [15:0]        lane_half;
    logic [31:0]        load_data;

    // Decode of the instruction presented by EX
    always_comb begin
        is_mem   = mem_read_in | mem_write_in;
        is_load  = mem_read_in;
        f3_ok    = is_load ? (funct3_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                           : (funct3_in inside {3'b000, 3'b001, 3'b010});
        misalign = ((funct3_in[1:0] == 2'b01) & address_in[0]) |
                   ((funct3_in[1:0] == 2'b10) & (address_in[1:0] != 2'b00));
        // The store that just finished is still held by EX for one cycle; don't replay it.
        start    = valid_in & is_mem & f3_ok & ~misalign & ~store_done;
    end

    // Store byte lanes and replicated write data
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = store_data_in;
        case (funct3_in[1:0])
            2'b00: begin
                st_be    = 4'b0001 << address_in[1:0];
                st_wdata = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                st_be    = address_in[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{store_data_in[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane select and extension
    always_comb begin
        lane_byte = dmem_rdata[{cap_addr[1:0], 3'b000} +: 8];
        lane_half = cap_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (cap_f3)
            3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_data = {24'd0, lane_byte};
            3'b101:  load_data = {16'd0, lane_half};
            default: load_data = dmem_rdata;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state;
        cap_load_d   = cap_load;
        cap_f3_d     = cap_f3;
        cap_addr_d   = cap_addr;
        cap_rd_d     = cap_rd;
        cap_wb_d     = cap_wb;
        store_done_d = 1'b0;
        valid_d      = 1'b0;
        err_d        = 1'b0;
        wb_d         = 1'b0;
        rd_d         = read_rd_out;
        addr_d       = data_address_out;
        data_d       = data_mem_out;
        req_d        = dmem_req;
        we_d         = dmem_we;
        daddr_d      = dmem_addr;
        be_d         = dmem_be;
        wdata_d      = dmem_wdata;
        stall_out    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    stall_out  = 1'b1;
                    state_d    = REQ;
                    cap_load_d = is_load;
                    cap_f3_d   = funct3_in;
                    cap_addr_d = address_in;
                    cap_rd_d   = read_rd_in;
                    cap_wb_d   = write_back_in;
                    req_d      = 1'b1;
                    we_d       = ~is_load;
                    daddr_d    = {address_in[31:2], 2'b00};
                    be_d       = is_load ? 4'b1111 : st_be;
                    wdata_d    = is_load ? 32'd0 : st_wdata;
                end else if (valid_in && !store_done) begin
                    valid_d = 1'b1;
                    addr_d  = address_in;
                    rd_d    = read_rd_in;
                    data_d  = 32'd0;
                    if (!is_mem) begin
                        wb_d = write_back_in;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            REQ: begin
                stall_out = 1'b1;
                if (dmem_gnt) begin
                    req_d = 1'b0;
                    if (cap_load) begin
                        state_d = WAIT;
                    end else begin
                        state_d      = IDLE;
                        store_done_d = 1'b1;
                        valid_d      = 1'b1;
                        addr_d       = cap_addr;
                        rd_d         = cap_rd;
                        data_d       = 32'd0;
                    end
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    addr_d  = cap_addr;
                    rd_d    = cap_rd;
                    wb_d    = cap_wb & cap_load;
                    data_d  = load_data;
                end else begin
                    stall_out = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state            <= IDLE;
            cap_load         <= 1'b0;
            cap_f3           <= 3'd0;
            cap_addr         <= 32'd0;
            cap_rd           <= 5'd0;
            cap_wb           <= 1'b0;
            store_done       <= 1'b0;
            valid_out        <= 1'b0;
            err_out          <= 1'b0;
            write_back_out   <= 1'b0;
            read_rd_out      <= 5'd0;
            data_address_out <= 32'd0;
            data_mem_out     <= 32'd0;
            dmem_req         <= 1'b0;
            dmem_we          <= 1'b0;
            dmem_addr        <= 32'd0;
            dmem_be          <= 4'd0;
            dmem_wdata       <= 32'd0;
        end else begin
            state            <= state_d;
            cap_load         <= cap_load_d;
            cap_f3           <= cap_f3_d;
            cap_addr         <= cap_addr_d;
            cap_rd           <= cap_rd_d;
            cap_wb           <= cap_wb_d;
            store_done       <= store_done_d;
            valid_out        <= valid_d;
            err_out          <= err_d;
            write_back_out   <= wb_d;
            read_rd_out      <= rd_d;
            data_address_out <= addr_d;
            data_mem_out     <= data_d;
            dmem_req         <= req_d;
            dmem_we          <= we_d;
            dmem_addr        <= daddr_d;
            dmem_be          <= be_d;
            dmem_wdata       <= wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: instruction-level reference model with a word memory,
// randomized instruction mix and bus delays, plus directed literal cases.
module tb_mem_access_unit;
    logic        clock = 1'b0;
    logic        resetn;
    logic        valid_in, mem_read_in, mem_write_in;
    logic [2:0]  funct3_in;
    logic [31:0] address_in, store_data_in;
    logic [4:0]  read_rd_in;
    logic        write_back_in;
    logic        stall_out, valid_out, write_back_out, err_out;
    logic [4:0]  read_rd_out;
    logic [31:0] data_address_out, data_mem_out;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    mem_access_unit dut (
        .clock(clock), .resetn(resetn), .valid_in(valid_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .funct3_in(funct3_in),
        .address_in(address_in), .store_data_in(store_data_in), .read_rd_in(read_rd_in),
        .write_back_in(write_back_in), .stall_out(stall_out), .valid_out(valid_out),
        .write_back_out(write_back_out), .read_rd_out(read_rd_out),
        .data_address_out(data_address_out), .data_mem_out(data_mem_out), .err_out(err_out),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        v, mr, mw;
        logic [2:0]  f3;
        logic [31:0] addr, sd;
        logic [4:0]  rd;
        logic        wb;
        int          g, r;
        logic        pin_d;
        logic [31:0] pin_dv;
        logic        pin_b;
        logic [3:0]  pin_be;
        logic [31:0] pin_wd, pin_da;
    } instr_t;

    typedef struct {
        logic        v, e, wb_chk, wb, full, d_chk, pin;
        logic [4:0]  rd;
        logic [31:0] addr, d, pin_v;
    } exp_t;

    localparam int BUBBLE = 0, ALU = 1, LOAD = 2, STORE = 3, BAD = 4;

    logic [31:0] mem [256];
    exp_t        ex;
    exp_t        none_e;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, want, $time);
        end
    endtask

    function automatic int classify(input instr_t t);
        int nbytes;
        logic legal;
        if (!t.v) return BUBBLE;
        if (!t.mr && !t.mw) return ALU;
        legal = t.mr ? (t.f3 != 3'd3 && t.f3 != 3'd6 && t.f3 != 3'd7) : (t.f3 < 3'd3);
        nbytes = 1 << t.f3[1:0];
        if (!legal || (t.addr % nbytes) != 0) return BAD;
        return t.mr ? LOAD : STORE;
    endfunction

    function automatic logic [31:0] load_value(input logic [31:0] w, input logic [31:0] a,
                                               input logic [2:0] f3);
        int unsigned b, h;
        b = (w >> (8 * (a % 4))) & 32'hff;
        h = (w >> (16 * ((a / 2) % 2))) & 32'hffff;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic store_lanes(input instr_t t, output logic [3:0] be, output logic [31:0] wd);
        int nbytes;
        logic [31:0] mask;
        nbytes = 1 << t.f3[1:0];
        mask = (nbytes == 4) ? 32'hffff_ffff : ((32'd1 << (8 * nbytes)) - 32'd1);
        be = 4'(((1 << nbytes) - 1) << (t.addr % 4));
        wd = 32'd0;
        for (int i = 0; i < 4; i += nbytes) wd |= (t.sd & mask) << (8 * i);
    endtask

    function automatic instr_t mk(input logic v, mr, mw, input logic [2:0] f3,
                                  input logic [31:0] addr, sd, input logic [4:0] rd,
                                  input logic wb, input int g, r);
        instr_t t;
        t.v = v; t.mr = mr; t.mw = mw; t.f3 = f3; t.addr = addr; t.sd = sd;
        t.rd = rd; t.wb = wb; t.g = g; t.r = r;
        t.pin_d = 1'b0; t.pin_dv = 32'd0; t.pin_b = 1'b0;
        t.pin_be = 4'd0; t.pin_wd = 32'd0; t.pin_da = 32'd0;
        return t;
    endfunction

    function automatic instr_t gen();
        instr_t t;
        int c, nbytes;
        logic [2:0] lf [5];
        lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        c = $urandom_range(0, 99);
        t = mk(1'b1, 1'b0, 1'b0, 3'($urandom), $urandom, $urandom, 5'($urandom),
               1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        if (c < 12) begin
            t.v = 1'b0; t.mr = 1'($urandom); t.mw = 1'($urandom);
        end else if (c < 35) begin
            t.mr = 1'b0; t.mw = 1'b0;
        end else if (c < 65) begin
            t.mr = 1'b1; t.mw = ($urandom_range(0, 3) == 0);
            t.f3 = lf[$urandom_range(0, 4)];
        end else if (c < 88) begin
            t.mw = 1'b1;
            t.f3 = 3'($urandom_range(0, 2));
        end else begin
            t.mr = 1'($urandom); t.mw = ~t.mr;
        end
        if (c >= 35 && c < 88) begin
            nbytes = 1 << t.f3[1:0];
            t.addr = t.addr & ~32'(nbytes - 1);
        end
        return t;
    endfunction

    task automatic check_outputs();
        chk("valid_out", valid_out, ex.v);
        chk("err_out", err_out, ex.e);
        if (ex.wb_chk) chk("write_back_out", write_back_out, ex.wb);
        if (ex.full) begin
            chk("read_rd_out", read_rd_out, ex.rd);
            chk("data_address_out", data_address_out, ex.addr);
        end
        if (ex.d_chk) chk("data_mem_out", data_mem_out, ex.d);
        if (ex.pin) chk("data_mem_out_literal", data_mem_out, ex.pin_v);
    endtask

    // Drive one instruction until EX would advance past it, checking every cycle.
    task automatic run_instr(input instr_t t);
        int kind, lat, cons, idx;
        logic [3:0] be;
        logic [31:0] wd;
        logic in_req, real_rv;
        exp_t r;
        kind = classify(t);
        lat  = (kind == LOAD) ? 3 + t.g + t.r : (kind == STORE) ? 2 + t.g : 1;
        cons = (kind == LOAD) ? lat - 1 : (kind == STORE) ? lat : 0;
        idx  = int'(t.addr[9:2]);
        if (kind == STORE) store_lanes(t, be, wd);
        else begin be = 4'hf; wd = 32'd0; end
        for (int k = 0; k <= cons; k++) begin
            @(negedge clock);
            check_outputs();
            in_req = (kind == LOAD || kind == STORE) && k >= 1 && k <= 1 + t.g;
            chk("dmem_req", dmem_req, in_req);
            if (in_req) begin
                chk("dmem_addr", dmem_addr, t.addr & ~32'h3);
                chk("dmem_we", dmem_we, kind == STORE);
                chk("dmem_be", dmem_be, be);
                if (kind == STORE) chk("dmem_wdata", dmem_wdata, wd);
                if (t.pin_b) begin
                    chk("dmem_addr_literal", dmem_addr, t.pin_da);
                    chk("dmem_be_literal", dmem_be, t.pin_be);
                    if (kind == STORE) chk("dmem_wdata_literal", dmem_wdata, t.pin_wd);
                end
            end
            valid_in = t.v; mem_read_in = t.mr; mem_write_in = t.mw; funct3_in = t.f3;
            address_in = t.addr; store_data_in = t.sd; read_rd_in = t.rd;
            write_back_in = t.wb;
            dmem_gnt = (kind == LOAD || kind == STORE) && k == 1 + t.g;
            real_rv  = (kind == LOAD) && k == 2 + t.g + t.r;
            dmem_rvalid = real_rv ||
                          ((kind != LOAD || k <= 1 + t.g) && $urandom_range(0, 3) == 0);
            dmem_rdata  = real_rv ? mem[idx] : $urandom;
            if (kind == STORE && k == 1 + t.g)
                for (int i = 0; i < 4; i++) if (be[i]) mem[idx][8*i +: 8] = wd[8*i +: 8];
            #1;
            chk("stall_out", stall_out, k < cons);
            r = none_e;
            if (k == lat - 1) begin
                r.v = (kind != BUBBLE);
                r.e = (kind == BAD);
                r.wb_chk = 1'b1;
                r.wb = (kind == ALU || kind == LOAD) ? t.wb : 1'b0;
                r.full = (kind == ALU || kind == LOAD || kind == STORE);
                r.rd = t.rd;
                r.addr = t.addr;
                r.d_chk = (kind == ALU || kind == LOAD);
                r.d = (kind == LOAD) ? load_value(mem[idx], t.addr, t.f3) : 32'd0;
                r.pin = t.pin_d;
                r.pin_v = t.pin_dv;
            end
            ex = r;
        end
    endtask

    initial begin
        instr_t t;
        none_e = '{v: 1'b0, e: 1'b0, wb_chk: 1'b0, wb: 1'b0, full: 1'b0, d_chk: 1'b0,
                   pin: 1'b0, rd: 5'd0, addr: 32'd0, d: 32'd0, pin_v: 32'd0};
        ex = none_e;
        resetn = 1'b0;
        valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0; funct3_in = 3'd0;
        address_in = 32'd0; store_data_in = 32'd0; read_rd_in = 5'd0; write_back_in = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[64]  = 32'h80FF_1234;
        mem[128] = 32'hBEEF_0000;
        repeat (2) @(negedge clock);
        chk("reset valid_out", valid_out, 0);
        chk("reset err_out", err_out, 0);
        chk("reset write_back_out", write_back_out, 0);
        chk("reset read_rd_out", read_rd_out, 0);
        chk("reset data_address_out", data_address_out, 0);
        chk("reset data_mem_out", data_mem_out, 0);
        chk("reset dmem_req", dmem_req, 0);
        chk("reset dmem_we", dmem_we, 0);
        chk("reset dmem_be", dmem_be, 0);
        chk("reset dmem_addr", dmem_addr, 0);
        resetn = 1'b1;

        // Directed cases
        run_instr(mk(1, 0, 0, 3'd0, 32'h0000_1234, 32'd0, 5'd5, 1, 0, 0));
        t = mk(1, 1, 0, 3'd0, 32'h0000_0103, 32'd0, 5'd6, 1, 0, 0);
        t.pin_d = 1; t.pin_dv = 32'hFFFF_FF80; t.pin_b = 1; t.pin_be = 4'hf; t.pin_da = 32'h100;
        run_instr(t);
        t = mk(1, 1, 0, 3'd5, 32'h0000_0202, 32'd0, 5'd7, 1, 2, 1);
        t.pin_d = 1; t.pin_dv = 32'h0000_BEEF;
        run_instr(t);
        t = mk(1, 0, 1, 3'd0, 32'h0000_0301, 32'h0000_00AB, 5'd8, 1, 0, 0);
        t.pin_b = 1; t.pin_be = 4'b0010; t.pin_wd = 32'hABAB_ABAB; t.pin_da = 32'h300;
        run_instr(t);
        run_instr(mk(1, 1, 0, 3'd2, 32'h0000_0402, 32'd0, 5'd9, 1, 0, 0));
        run_instr(mk(1, 1, 0, 3'd3, 32'h0000_0400, 32'd0, 5'd9, 1, 0, 0));
        run_instr(mk(0, 1, 0, 3'd2, 32'h0000_0500, 32'd0, 5'd1, 1, 0, 0));
        run_instr(mk(1, 0, 0, 3'd0, 32'hDEAD_0001, 32'd0, 5'd3, 1, 0, 0));
        run_instr(mk(1, 0, 0, 3'd0, 32'hDEAD_0002, 32'd0, 5'd4, 0, 0, 0));

        for (int n = 0; n < 400; n++) run_instr(gen());
        run_instr(mk(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0));

        // Reset while a load waits for its response; the late response must be ignored.
        t = mk(1, 1, 0, 3'd2, 32'h0000_0040, 32'd0, 5'd10, 1, 0, 0);
        @(negedge clock);
        check_outputs();
        valid_in = 1; mem_read_in = 1; mem_write_in = 0; funct3_in = t.f3;
        address_in = t.addr; read_rd_in = t.rd; write_back_in = 1;
        dmem_gnt = 0; dmem_rvalid = 0;
        @(negedge clock);
        chk("rst_wait dmem_req", dmem_req, 1);
        dmem_gnt = 1;
        @(negedge clock);
        dmem_gnt = 0;
        #1 chk("rst_wait stall_out", stall_out, 1);
        #1 resetn = 1'b0;
        #1 chk("rst_wait dmem_req", dmem_req, 0);
        chk("rst_wait valid_out", valid_out, 0);
        @(negedge clock);
        resetn = 1'b1; valid_in = 0; dmem_rvalid = 1; dmem_rdata = 32'h1234_5678;
        @(negedge clock);
        chk("late rvalid valid_out", valid_out, 0);
        dmem_rvalid = 0;
        @(negedge clock);
        chk("late rvalid valid_out", valid_out, 0);

        // Reset during REQ drops the request asynchronously.
        valid_in = 1;
        @(negedge clock);
        chk("rst_req dmem_req", dmem_req, 1);
        #2 resetn = 1'b0;
        #1 chk("rst_req dmem_req", dmem_req, 0);
        @(negedge clock);
        resetn = 1'b1; valid_in = 0;
        ex = none_e;
        run_instr(t);
        run_instr(mk(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit of the RV32I pipeline. It takes the instruction leaving EX, runs the data-memory bus transaction (req/gnt/rvalid), aligns and extends load data, and stalls upstream while the bus is busy. It presents one registered result per instruction to the MEM/WB register on `write_back_out`, `data_address_out`, `read_rd_out`, `data_mem_out`.

## Interface
- No parameters. XLEN is fixed at 32.
- `clock` in 1: single clock. Everything is rising-edge.
- `resetn` in 1: asynchronous, active-low reset.
- `valid_in` in 1: an instruction from EX is present.
- `mem_read_in`, `mem_write_in` in 1 each: load or store. Both high is treated as a load.
- `funct3_in` in 3: access size and sign.
- `address_in` in 32: ALU result, which is the effective address for memory ops.
- `store_data_in` in 32: rs2 value.
- `read_rd_in` in 5: destination register.
- `write_back_in` in 1: register-write enable.
- `stall_out` out 1: hold EX/MEM inputs. Combinational.
- `valid_out` out 1: result valid for one cycle.
- `write_back_out` out 1, `read_rd_out` out 5, `data_address_out` out 32, `data_mem_out` out 32: registered outputs to MEM/WB.
- `err_out` out 1: misaligned access or illegal funct3. One-cycle pulse with `valid_out`.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 32 (word-aligned, bits [1:0] = 0), `dmem_be` out 4, `dmem_wdata` out 32: data-memory request.
- `dmem_gnt` in 1, `dmem_rvalid` in 1, `dmem_rdata` in 32: data-memory response.

## Operation
- FSM states: IDLE, REQ, WAIT.
- **IDLE, start condition:** start = `valid_in` & (`mem_read_in` | `mem_write_in`) & access aligned & funct3 legal.
  - On start, capture all inputs into internal registers and go to REQ.
- **IDLE, non-memory instruction:** when `valid_in` is high with no memory op, pass it through in one cycle:
  - `data_address_out` <= `address_in`
  - `data_mem_out` <= 0
  - `read_rd_out`, `write_back_out` <= inputs
  - `valid_out` <= 1
- **IDLE, bad memory op:** when `valid_in` is high and the memory op is misaligned or illegal, do not start a bus access.
  - Next cycle: `valid_out` = 1, `err_out` = 1, `write_back_out` = 0.
- **Legal funct3:**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000, 001, 010.
- **Misaligned:** a half access with addr[0] = 1, or a word access with addr[1:0] ≠ 0.
- **REQ:**
  - `dmem_req` = 1 and `dmem_addr` = {addr[31:2], 2'b00}.
  - Hold the request until `dmem_gnt`.
  - On gnt, a store completes and a load goes to WAIT.
- **WAIT:** on `dmem_rvalid` the load completes. A `dmem_rvalid` seen in REQ or IDLE is ignored.
- **Completion:** at the completing edge, go to IDLE and set:
  - `valid_out` <= 1
  - `data_address_out` <= captured address
  - `read_rd_out` <= captured rd
  - `write_back_out` <= captured write_back & load (stores are forced to 0)
- **Store lanes:**
  - SB: `dmem_be` = 1 << addr[1:0]; wdata = byte replicated ×4.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = half replicated ×2.
  - SW: be = 4'b1111; wdata = rs2.
  - Loads: `dmem_we` = 0 and be = 4'b1111.
- **Load data:** select the lane using captured addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU). LW passes the word through.
- **Stall:** `stall_out` = (IDLE & start) | REQ | (WAIT & !`dmem_rvalid`).
  - In the completing cycle `stall_out` is low, so EX advances on the same edge that MEM/WB is written.
  - For stores, `stall_out` is high throughout REQ, including the gnt cycle.
- **Bubble:** in IDLE with `valid_in` = 0, next cycle `valid_out` = 0 and `write_back_out` = 0.

## Timing
- **Reset:** all outputs are 0 and the state is IDLE. Asserting `resetn` mid-transaction drops `dmem_req` immediately (asynchronous). An outstanding load response after reset is ignored.
- **Load, zero-wait memory:**
  - Cycle 0: IDLE, stall = 1.
  - Cycle 1: REQ, gnt = 1.
  - Cycle 2: WAIT, rvalid = 1, stall = 0.
  - Cycle 3: `valid_out` = 1.
  - Total latency 3 cycles. Each extra cycle of gnt or rvalid delay adds one cycle.
- **Store, zero-wait memory:** cycle 0 IDLE, cycle 1 REQ with gnt, `valid_out` in cycle 2. Latency 2 cycles.
- **Non-memory instruction:** 1 cycle, no stall. Back-to-back non-memory instructions give `valid_out` every cycle.
- **Bus outputs:** `dmem_*` are driven from captured registers and are stable throughout REQ.

## Test plan
- **Non-memory pass-through:** ALU op with addr = 0x0000_1234, rd = 5, wb = 1 → next cycle `valid_out` = 1, `data_address_out` = 0x1234, rd = 5, wb = 1, stall never high.
- **LB sign-extend:** LB at 0x103, rdata = 0x80FF_1234, gnt and rvalid zero-wait → `dmem_addr` = 0x100, `data_mem_out` = 0xFFFF_FF80, `valid_out` in cycle 3, stall high for cycles 0–1.
- **LHU with delays:** LHU at 0x202, rdata = 0xBEEF_0000, gnt delayed 2 cycles and rvalid delayed 1 cycle → `data_mem_out` = 0x0000_BEEF, latency 6, `dmem_req` held steady until gnt.
- **SB lane select:** SB at 0x301, rs2 = 0x0000_00AB → `dmem_we` = 1, be = 4'b0010, wdata = 0xABAB_ABAB, then `valid_out` with wb = 0.
- **Misaligned / illegal:** LW at 0x402 → no `dmem_req`, next cycle `valid_out` = `err_out` = 1, wb = 0. Repeat with funct3 = 011 → same response.
- **Reset mid-load:** drop `resetn` while in WAIT → `dmem_req` = 0 and `valid_out` = 0 immediately. A later rvalid is ignored, and the next LW after reset completes normally.
